// File: rtl/regfile_param_if.sv
// regfile_param_if: register-file bus (write ports E/M, read ports A/B, sweep control, debug dump)
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0]       dstE;
  logic [DATA_W-1:0]       valE;
  logic [ADDR_W-1:0]       dstM;
  logic [DATA_W-1:0]       valM;
  logic [ADDR_W-1:0]       rA;
  logic [ADDR_W-1:0]       rB;
  logic [DATA_W-1:0]       valA;
  logic [DATA_W-1:0]       valB;
  logic                    clr_req;
  logic                    clr_busy;
  logic                    wr_conflict;
  logic [NREGS*DATA_W-1:0] regs_flat;
  modport master (
    output dstE, valE, dstM, valM, rA, rB, clr_req,
    input  valA, valB, clr_busy, wr_conflict, regs_flat
  );
  modport slave (
    input  dstE, valE, dstM, valM, rA, rB, clr_req,
    output valA, valB, clr_busy, wr_conflict, regs_flat
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: NREGS x DATA_W register file, write ports E/M (M wins), read ports A/B, clear sweep, conflict flag; REGFILE_BYPASS_EN enables write-to-read bypass
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 4,
  parameter int RNONE  = 15
) (
  input logic            clock,
  input logic            reset,
  regfile_param_if.slave bus
);
  typedef enum logic {IDLE, SWEEP} state_t;
  localparam logic [ADDR_W-1:0] NR   = ADDR_W'(NREGS);
  localparam logic [ADDR_W-1:0] NONE = ADDR_W'(RNONE);
  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              conflict_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] rd_src [NREGS];
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              we_e;
  logic              we_m;
  assign we_e = bus.dstE != NONE && bus.dstE < NR;
  assign we_m = bus.dstM != NONE && bus.dstM < NR;
  // sweep clear beats both ports, M beats E
  always_comb begin
    for (int i = 0; i < NREGS; i++)
      regs_d[i] = (state_q == SWEEP && cnt_q == ADDR_W'(i)) ? '0 :
                  (we_m && bus.dstM == ADDR_W'(i)) ? bus.valM :
                  (we_e && bus.dstE == ADDR_W'(i)) ? bus.valE : regs_q[i];
  end
`ifdef REGFILE_BYPASS_EN
  assign rd_src = regs_d;
`else
  assign rd_src = regs_q;
`endif
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      rd_a = (bus.rA == ADDR_W'(i)) ? rd_src[i] : rd_a;
      rd_b = (bus.rB == ADDR_W'(i)) ? rd_src[i] : rd_b;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      regs_q     <= '{default: '0};
    end else begin
      regs_q     <= regs_d;
      conflict_q <= we_e && we_m && bus.dstE == bus.dstM;
      if (state_q == IDLE) begin
        if (bus.clr_req) begin
          state_q <= SWEEP;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      end else if (cnt_q == ADDR_W'(NREGS - 1)) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign bus.regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end
  assign bus.valA        = rd_a;
  assign bus.valB        = rd_b;
  assign bus.clr_busy    = busy_q;
  assign bus.wr_conflict = conflict_q;
endmodule
